// File: rtl/elastic_pkg.sv
// Shared types and constants for the elastic stream generator and its LFSR.
package elastic_pkg;

  localparam int unsigned LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11, Galois (right-shift) form.
  localparam logic [LFSR_W-1:0] LFSR16_TAPS = 16'hB400;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  // One Galois LFSR step.
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] cur);
    lfsr16_next = cur[0] ? ((cur >> 1) ^ LFSR16_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/elastic_lfsr16.sv
// 16-bit Galois LFSR with load-on-reset and step enable.
//   clk  : clock
//   srst : synchronous active-high reset, loads seed
//   en   : advance one step this cycle
//   seed : reset value, must be nonzero
//   q    : current LFSR state
module elastic_lfsr16
  import elastic_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (srst) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr16_next(q);
    end
  end

endmodule

// File: rtl/elastic_traffic_gen.sv
// Valid/ready stream transmitter: sends num_words incrementing words from
// seed_data per accepted start, with LFSR-driven bubbles set by throttle.
//   clk, srst    : clock, synchronous active-high reset
//   start        : begin a burst (ignored while busy)
//   num_words    : burst length, sampled on accepted start
//   seed_data    : first data word, sampled on accepted start
//   throttle     : bubble density 0..15
//   data, valid  : stream output, ready : stream backpressure
//   busy         : burst in progress
//   done         : one-cycle pulse at burst completion
//   words_sent   : handshakes in current/last burst
module elastic_traffic_gen
  import elastic_pkg::*;
#(
  parameter int unsigned       DWIDTH    = 32,
  parameter int unsigned       COUNT_W   = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  input  logic [DWIDTH-1:0]  seed_data,
  input  logic [3:0]         throttle,
  output logic [DWIDTH-1:0]  data,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] words_sent
);

  gen_state_t         state;
  logic [COUNT_W-1:0] count;
  logic [LFSR_W-1:0]  lfsr;
  logic               bubble;
  logic               last_word;

  // LFSR only steps while a burst is running.
  elastic_lfsr16 u_lfsr (
    .clk  (clk),
    .srst (srst),
    .en   (state == RUN),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign bubble    = (lfsr[3:0] < throttle);
  assign last_word = (words_sent == (count - COUNT_W'(1)));

  // Burst FSM with counters and data register; every output is a flop.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      count      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              done <= 1'b1;
            end else begin
              count      <= num_words;
              data       <= seed_data;
              words_sent <= '0;
              valid      <= 1'b0;
              busy       <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (!valid) begin
            valid <= !bubble;
          end else if (ready) begin
            words_sent <= words_sent + COUNT_W'(1);
            if (last_word) begin
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              data  <= data + DWIDTH'(1);
              valid <= !bubble;
            end
          end
          // valid && !ready: everything holds so the word stays stable.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elastic_traffic_gen.sv
// Directed bench for elastic_traffic_gen with a data scoreboard and
// a stream protocol monitor.
module tb_elastic_traffic_gen;

  localparam int unsigned DWIDTH  = 32;
  localparam int unsigned COUNT_W = 16;

  logic               clk = 1'b0;
  logic               srst;
  logic               start;
  logic [COUNT_W-1:0] num_words;
  logic [DWIDTH-1:0]  seed_data;
  logic [3:0]         throttle;
  logic [DWIDTH-1:0]  data;
  logic               valid;
  logic               ready;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] words_sent;

  int checks   = 0;
  int failures = 0;

  logic [DWIDTH-1:0] exp_q[$];
  int                hs_count    = 0;
  int                done_count  = 0;
  int                bubble_count = 0;
  int                cycle       = 0;
  int                first_hs_cycle = 0;
  int                last_hs_cycle  = 0;
  logic              prev_stall = 1'b0;
  logic [DWIDTH-1:0] prev_data  = '0;

  elastic_traffic_gen #(
    .DWIDTH   (DWIDTH),
    .COUNT_W  (COUNT_W),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .start      (start),
    .num_words  (num_words),
    .seed_data  (seed_data),
    .throttle   (throttle),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor at negedge: inputs are settled, so valid&&ready here means a
  // transfer at the coming posedge.
  always @(negedge clk) begin
    cycle++;
    if (done) done_count++;
    if (busy && !valid) bubble_count++;
    if (srst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid), 64'(1'b1));
        chk("hold_data", 64'(data), 64'(prev_data));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(data), 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          chk("data", 64'(data), 64'(exp_q.pop_front()));
        end
        if (hs_count == 0) first_hs_cycle = cycle;
        last_hs_cycle = cycle;
        hs_count++;
      end
      prev_stall = valid && !ready;
      prev_data  = data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    if (!done) chk("done_timeout", 64'(done), 64'(1'b1));
  endtask

  task automatic kick(input logic [COUNT_W-1:0] n, input logic [DWIDTH-1:0] seed);
    start     = 1'b1;
    num_words = n;
    seed_data = seed;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(seed + DWIDTH'(i));
    step();
    start = 1'b0;
  endtask

  initial begin
    int dc;
    int hc;
    srst = 1'b1; start = 1'b0; num_words = '0; seed_data = '0;
    throttle = 4'd0; ready = 1'b1;
    step(); step();
    srst = 1'b0;
    chk("rst_valid", 64'(valid), 64'(1'b0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_done", 64'(done), 64'(1'b0));
    chk("rst_words", 64'(words_sent), 64'(0));

    // 1: full throughput burst.
    hs_count = 0; dc = done_count;
    kick(16'd4, 32'h10);
    chk("t1_lat_valid0", 64'(valid), 64'(1'b0));
    chk("t1_busy", 64'(busy), 64'(1'b1));
    step();
    chk("t1_lat_valid1", 64'(valid), 64'(1'b1));
    chk("t1_first_data", 64'(data), 64'h10);
    wait_done(50);
    chk("t1_words", 64'(words_sent), 64'(4));
    chk("t1_idle", 64'(busy), 64'(1'b0));
    step();
    chk("t1_done_once", 64'(done_count - dc), 64'(1));
    chk("t1_hs", 64'(hs_count), 64'(4));
    chk("t1_consecutive", 64'(last_hs_cycle - first_hs_cycle), 64'(3));
    chk("t1_queue", 64'(exp_q.size()), 64'(0));

    // 2: backpressure holds the first word.
    ready = 1'b0;
    kick(16'd1, 32'h55);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", 64'(valid), 64'(1'b1));
      chk("t2_data_held", 64'(data), 64'h55);
      step();
    end
    ready = 1'b1;
    wait_done(10);
    chk("t2_words", 64'(words_sent), 64'(1));
    step();

    // 3: heavy throttling, long burst.
    hs_count = 0; bubble_count = 0;
    throttle = 4'd15;
    kick(16'd100, 32'h1000);
    wait_done(20000);
    step();
    chk("t3_hs", 64'(hs_count), 64'(100));
    chk("t3_words", 64'(words_sent), 64'(100));
    chk("t3_bubbles", 64'(bubble_count > 10), 64'(1'b1));
    chk("t3_queue", 64'(exp_q.size()), 64'(0));
    throttle = 4'd0;

    // 4: data wraps.
    kick(16'd3, 32'hFFFF_FFFE);
    wait_done(20);
    chk("t4_words", 64'(words_sent), 64'(3));
    step();
    chk("t4_queue", 64'(exp_q.size()), 64'(0));

    // 5: zero-length burst, then a start while busy.
    dc = done_count;
    start = 1'b1; num_words = '0; seed_data = 32'h77;
    step();
    start = 1'b0;
    chk("t5_done", 64'(done), 64'(1'b1));
    chk("t5_busy", 64'(busy), 64'(1'b0));
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_valid", 64'(valid), 64'(1'b0));
      step();
    end
    chk("t5_done_once", 64'(done_count - dc), 64'(1));
    kick(16'd5, 32'h200);
    step();
    start = 1'b1; num_words = 16'd9; seed_data = 32'hDEAD;
    step();
    start = 1'b0;
    wait_done(30);
    chk("t5_words", 64'(words_sent), 64'(5));
    step();
    chk("t5_queue", 64'(exp_q.size()), 64'(0));
    chk("t5_still_idle", 64'(busy), 64'(1'b0));

    // 6: reset during a stall, then a clean burst.
    ready = 1'b0;
    kick(16'd4, 32'h300);
    step();
    chk("t6_stalled", 64'(valid), 64'(1'b1));
    srst = 1'b1;
    step();
    srst = 1'b0;
    exp_q.delete();
    chk("t6_valid", 64'(valid), 64'(1'b0));
    chk("t6_busy", 64'(busy), 64'(1'b0));
    chk("t6_words", 64'(words_sent), 64'(0));
    chk("t6_data", 64'(data), 64'(0));
    ready = 1'b1;
    hc = hs_count;
    kick(16'd2, 32'h400);
    wait_done(20);
    chk("t6_new_words", 64'(words_sent), 64'(2));
    step();
    chk("t6_new_hs", 64'(hs_count - hc), 64'(2));
    chk("t6_queue", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
